multi_lane_parity_tracker: RTL and testbench

//  Framed, W-lane generalisation of the running x^y parity accumulator.
//  - Each lane i holds one toggle flip-flop: acc[i] <= acc[i]^x[i]^y[i] on every accepted sample.
//  - After FRAME_LEN accepted samples: pulses frame_done and holds the frame result.
//  - Sits between a dual-source sampler and the checker/status logic.

---
 rtl/parity_tracker_pkg.sv | 15 +
 rtl/parity_lane.sv | 23 ++
 rtl/multi_lane_parity_tracker.sv | 111 +++++++++++
 tb/tb_multi_lane_parity_tracker.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/parity_tracker_pkg.sv
// Shared types for the multi-lane parity tracker.
// State encoding and sample-counter width helper.
package parity_tracker_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic int cnt_w(input int frame_len);
        return $clog2(frame_len + 1);
    endfunction

endpackage

// File: rtl/parity_lane.sv
// One parity lane: a toggle flop folding d_x^d_y into q.
// Priority: reset > clr > en.
module parity_lane (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    input  logic d_x,
    input  logic d_y,
    output logic q
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= 1'b0;
        end else if (clr) begin
            q <= 1'b0;
        end else if (en) begin
            q <= q ^ d_x ^ d_y;
        end
    end

endmodule

// File: rtl/multi_lane_parity_tracker.sv
// Framed W-lane x^y parity accumulator with frame sequencing FSM.
// Define MISMATCH_CNT_EN to add the saturating mismatch_cnt output.
module multi_lane_parity_tracker
    import parity_tracker_pkg::*;
#(
    parameter int W         = 4,
    parameter int FRAME_LEN = 8,
    parameter int CNT_W     = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          clear,
    input  logic                          in_valid,
    input  logic [W-1:0]                  x,
    input  logic [W-1:0]                  y,
    input  logic                          odd_mode,
    output logic [W-1:0]                  lane_parity,
    output logic                          word_parity,
    output logic                          busy,
    output logic                          frame_done,
    output logic [cnt_w(FRAME_LEN)-1:0]   sample_cnt
`ifdef MISMATCH_CNT_EN
    ,
    output logic [CNT_W-1:0]              mismatch_cnt
`endif
);

    localparam int SC_W = cnt_w(FRAME_LEN);
    localparam logic [SC_W-1:0] LAST = SC_W'(FRAME_LEN - 1);

    state_t         state;
    logic [W-1:0]   acc;
    logic           accept;
    logic           restart;
    logic           lane_clr;

    assign accept   = (state == ACCUM) && in_valid;
    assign restart  = start && (state != ACCUM);
    assign lane_clr = clear || restart;

    for (genvar i = 0; i < W; i++) begin : g_lane
        parity_lane u_lane (
            .clk   (clk),
            .reset (reset),
            .clr   (lane_clr),
            .en    (accept),
            .d_x   (x[i]),
            .d_y   (y[i]),
            .q     (acc[i])
        );
    end

    assign lane_parity = acc ^ {W{odd_mode}};
    assign word_parity = (^acc) ^ odd_mode;

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            state      <= IDLE;
            sample_cnt <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state      <= ACCUM;
                        sample_cnt <= '0;
                        busy       <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        sample_cnt <= sample_cnt + SC_W'(1);
                        if (sample_cnt == LAST) begin
                            state      <= DONE;
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (start) begin
                        state      <= ACCUM;
                        sample_cnt <= '0;
                        busy       <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef MISMATCH_CNT_EN
    // Cumulative across frames; sticks at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            mismatch_cnt <= '0;
        end else if (accept && (x != y) && (mismatch_cnt != '1)) begin
            mismatch_cnt <= mismatch_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_multi_lane_parity_tracker.sv
// Directed bench for multi_lane_parity_tracker (W=4, FRAME_LEN=4, CNT_W=2).
// Mismatch-counter scenario runs only when MISMATCH_CNT_EN is defined.
module tb_multi_lane_parity_tracker;

    logic       clk;
    logic       reset;
    logic       start;
    logic       clear;
    logic       in_valid;
    logic [3:0] x;
    logic [3:0] y;
    logic       odd_mode;
    logic [3:0] lane_parity;
    logic       word_parity;
    logic       busy;
    logic       frame_done;
    logic [2:0] sample_cnt;
`ifdef MISMATCH_CNT_EN
    logic [1:0] mismatch_cnt;
`endif

    int n_cmp;
    int n_bad;

    multi_lane_parity_tracker #(
        .W         (4),
        .FRAME_LEN (4),
        .CNT_W     (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .clear        (clear),
        .in_valid     (in_valid),
        .x            (x),
        .y            (y),
        .odd_mode     (odd_mode),
        .lane_parity  (lane_parity),
        .word_parity  (word_parity),
        .busy         (busy),
        .frame_done   (frame_done),
        .sample_cnt   (sample_cnt)
`ifdef MISMATCH_CNT_EN
        ,
        .mismatch_cnt (mismatch_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        odd_mode = 1'b0;
        tick();
        tick();
        if (lane_parity !== 4'b0000) begin
            n_bad++;
            $display("FAIL rst_lane got %b want 0000", lane_parity);
        end
        n_cmp++;
        if (word_parity !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_word got %b want 0", word_parity);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_busy got %b want 0", busy);
        end
        n_cmp++;
        if (frame_done !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_done got %b want 0", frame_done);
        end
        n_cmp++;
        if (sample_cnt !== 3'd0) begin
            n_bad++;
            $display("FAIL rst_cnt got %0d want 0", sample_cnt);
        end
        n_cmp++;
`ifdef MISMATCH_CNT_EN
        if (mismatch_cnt !== 2'd0) begin
            n_bad++;
            $display("FAIL rst_mm got %0d want 0", mismatch_cnt);
        end
        n_cmp++;
`endif
        reset = 1'b1;
        // Samples offered while idle must not move anything.
        in_valid = 1'b1;
        x = 4'b1111;
        y = 4'b0000;
        tick();
        in_valid = 1'b0;
        if (lane_parity !== 4'b0000 || sample_cnt !== 3'd0) begin
            n_bad++;
            $display("FAIL idle_ignore got %b/%0d want 0000/0",
                     lane_parity, sample_cnt);
        end
        n_cmp++;
    endtask

    task automatic test_frame(input logic odd, input logic [3:0] exp_lane,
                              input logic exp_word);
        odd_mode = odd;
        start = 1'b1;
        tick();
        start = 1'b0;
        if (busy !== 1'b1 || sample_cnt !== 3'd0) begin
            n_bad++;
            $display("FAIL frm_start got busy=%b cnt=%0d want 1/0",
                     busy, sample_cnt);
        end
        n_cmp++;
        in_valid = 1'b1;
        x = 4'b0001;
        y = 4'b0000;
        tick();
        if (lane_parity !== (4'b0001 ^ {4{odd}})) begin
            n_bad++;
            $display("FAIL frm_s1 got %b want %b",
                     lane_parity, 4'b0001 ^ {4{odd}});
        end
        n_cmp++;
        tick();
        if (lane_parity !== (4'b0000 ^ {4{odd}}) || sample_cnt !== 3'd2) begin
            n_bad++;
            $display("FAIL frm_s2 got %b/%0d want %b/2",
                     lane_parity, sample_cnt, {4{odd}});
        end
        n_cmp++;
        tick();
        if (frame_done !== 1'b0) begin
            n_bad++;
            $display("FAIL frm_s3_done got %b want 0", frame_done);
        end
        n_cmp++;
        x = 4'b1010;
        y = 4'b1010;
        tick();
        in_valid = 1'b0;
        if (frame_done !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL frm_done got done=%b busy=%b want 1/0",
                     frame_done, busy);
        end
        n_cmp++;
        if (lane_parity !== exp_lane || word_parity !== exp_word) begin
            n_bad++;
            $display("FAIL frm_result got %b/%b want %b/%b",
                     lane_parity, word_parity, exp_lane, exp_word);
        end
        n_cmp++;
        if (sample_cnt !== 3'd4) begin
            n_bad++;
            $display("FAIL frm_cnt got %0d want 4", sample_cnt);
        end
        n_cmp++;
        tick();
        if (frame_done !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL frm_after got done=%b busy=%b want 0/0",
                     frame_done, busy);
        end
        n_cmp++;
        if (lane_parity !== exp_lane) begin
            n_bad++;
            $display("FAIL frm_hold got %b want %b", lane_parity, exp_lane);
        end
        n_cmp++;
        // Back in IDLE: a late sample is ignored.
        in_valid = 1'b1;
        x = 4'b0110;
        y = 4'b0000;
        tick();
        in_valid = 1'b0;
        if (lane_parity !== exp_lane || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL frm_idle got %b busy=%b want %b busy=0",
                     lane_parity, busy, exp_lane);
        end
        n_cmp++;
        odd_mode = 1'b0;
    endtask

    task automatic test_clear();
        start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        y = 4'b0000;
        x = 4'b0001;
        tick();
        x = 4'b0010;
        tick();
        if (lane_parity !== 4'b0011 || sample_cnt !== 3'd2) begin
            n_bad++;
            $display("FAIL clr_pre got %b/%0d want 0011/2",
                     lane_parity, sample_cnt);
        end
        n_cmp++;
        clear = 1'b1;
        x = 4'b0100;
        tick();
        clear = 1'b0;
        in_valid = 1'b0;
        if (lane_parity !== 4'b0000 || sample_cnt !== 3'd0) begin
            n_bad++;
            $display("FAIL clr_state got %b/%0d want 0000/0",
                     lane_parity, sample_cnt);
        end
        n_cmp++;
        if (busy !== 1'b0 || frame_done !== 1'b0) begin
            n_bad++;
            $display("FAIL clr_flags got busy=%b done=%b want 0/0",
                     busy, frame_done);
        end
        n_cmp++;
    endtask

    task automatic test_clear_on_last();
        start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        x = 4'b1000;
        y = 4'b0000;
        tick();
        tick();
        tick();
        if (sample_cnt !== 3'd3) begin
            n_bad++;
            $display("FAIL cl4_pre got %0d want 3", sample_cnt);
        end
        n_cmp++;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        in_valid = 1'b0;
        if (frame_done !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL cl4_done got done=%b busy=%b want 0/0",
                     frame_done, busy);
        end
        n_cmp++;
        tick();
        if (frame_done !== 1'b0 || lane_parity !== 4'b0000) begin
            n_bad++;
            $display("FAIL cl4_after got done=%b lane=%b want 0/0000",
                     frame_done, lane_parity);
        end
        n_cmp++;
    endtask

    task automatic test_reset_mid_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        x = 4'b1111;
        y = 4'b0000;
        tick();
        tick();
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        in_valid = 1'b0;
        if (busy !== 1'b0 || sample_cnt !== 3'd0 || lane_parity !== 4'b0000) begin
            n_bad++;
            $display("FAIL rmid_rst got busy=%b cnt=%0d lane=%b want 0/0/0000",
                     busy, sample_cnt, lane_parity);
        end
        n_cmp++;
        start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        x = 4'b0100;
        y = 4'b0000;
        tick();
        if (sample_cnt !== 3'd1 || lane_parity !== 4'b0100) begin
            n_bad++;
            $display("FAIL rmid_s1 got %0d/%b want 1/0100",
                     sample_cnt, lane_parity);
        end
        n_cmp++;
        x = 4'b0011;
        y = 4'b0011;
        tick();
        tick();
        tick();
        in_valid = 1'b0;
        if (frame_done !== 1'b1 || lane_parity !== 4'b0100
            || word_parity !== 1'b1) begin
            n_bad++;
            $display("FAIL rmid_done got done=%b lane=%b word=%b want 1/0100/1",
                     frame_done, lane_parity, word_parity);
        end
        n_cmp++;
        tick();
    endtask

`ifdef MISMATCH_CNT_EN
    task automatic test_mismatch_cnt();
        int pulses;
        logic [1:0] exp_mm [0:10];
        exp_mm = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3,
                   2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
        clear = 1'b1;
        tick();
        clear = 1'b0;
        pulses = 0;
        start = 1'b1;
        in_valid = 1'b1;
        x = 4'b0001;
        y = 4'b0000;
        for (int e = 0; e < 11; e++) begin
            if (e == 10) start = 1'b0;
            tick();
            if (frame_done === 1'b1) pulses++;
            if (mismatch_cnt !== exp_mm[e]) begin
                n_bad++;
                $display("FAIL mm_edge%0d got %0d want %0d",
                         e, mismatch_cnt, exp_mm[e]);
            end
            n_cmp++;
        end
        start = 1'b0;
        in_valid = 1'b0;
        if (pulses !== 2) begin
            n_bad++;
            $display("FAIL mm_pulses got %0d want 2", pulses);
        end
        n_cmp++;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        if (mismatch_cnt !== 2'd0) begin
            n_bad++;
            $display("FAIL mm_clear got %0d want 0", mismatch_cnt);
        end
        n_cmp++;
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b0;
        start = 1'b0;
        clear = 1'b0;
        in_valid = 1'b0;
        x = 4'b0000;
        y = 4'b0000;
        odd_mode = 1'b0;
        test_reset();
        test_frame(1'b0, 4'b0001, 1'b1);
        test_frame(1'b1, 4'b1110, 1'b0);
        test_clear();
        test_clear_on_last();
        test_reset_mid_frame();
`ifdef MISMATCH_CNT_EN
        test_mismatch_cnt();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
